// File: rtl/decim_pkg.sv
// Shared constants and types for the 2x halfband decimator.
package decim_pkg;

  localparam int unsigned DW       = 16;
  localparam int unsigned ACC_W    = DW + 6;
  localparam int unsigned RND      = 16;
  localparam int unsigned SHIFT    = 5;
  localparam int unsigned FILL_MIN = 7;
  localparam int unsigned LATENCY  = 3;
  localparam int unsigned NLANE    = 8;

  // Taps are -1, 0, 9, 16, 9, 0, -1: 9 = (1 << 3) + 1 and 16 = 1 << 4.
  localparam int unsigned COEF_MID_SH = 3;
  localparam int unsigned COEF_CTR_SH = 4;

  typedef logic signed [DW-1:0]    sample_t;
  typedef logic signed [ACC_W-1:0] acc_t;

endpackage

// File: rtl/decim_2x_if.sv
// Sample-lane bus for decim_2x: eight input lanes with a valid strobe, eight decimated outputs.
interface decim_2x_if;
  import decim_pkg::*;

  logic             in_vld;
  sample_t          din0, din1, din2, din3, din4, din5, din6, din7;
  logic             out_vld;
  sample_t          dout0, dout1, dout2, dout3, dout4, dout5, dout6, dout7;
  logic [NLANE-1:0] ovf;

  modport master (
    output in_vld, din0, din1, din2, din3, din4, din5, din6, din7,
    input  out_vld, dout0, dout1, dout2, dout3, dout4, dout5, dout6, dout7, ovf
  );

  modport slave (
    input  in_vld, din0, din1, din2, din3, din4, din5, din6, din7,
    output out_vld, dout0, dout1, dout2, dout3, dout4, dout5, dout6, dout7, ovf
  );

endinterface

// File: rtl/decim_hb_ch.sv
// One decimator lane: delay line plus pre-add / weight / round-saturate pipeline.
// DECIM_FIR_EN selects the halfband filter; otherwise the lane just forwards x0.
module decim_hb_ch
  import decim_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    in_vld,
  input  sample_t din,
  input  logic    ld,
  output sample_t dout,
  output logic    ovf
);

  sample_t dout_d, dout_q;
  logic    ovf_d, ovf_q;

`ifdef DECIM_FIR_EN
  localparam int SMAX = (1 << (DW - 1)) - 1;
  localparam int SMIN = -SMAX - 1;

  sample_t x_q [7];
  acc_t    s1_a_q, s1_b_q, s1_c_q, acc_q, rnd;

  // Data stages run freely; only the output register is qualified by ld.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 7; i++) x_q[i] <= '0;
      s1_a_q <= '0;
      s1_b_q <= '0;
      s1_c_q <= '0;
      acc_q  <= '0;
    end else begin
      if (in_vld) begin
        x_q[0] <= din;
        for (int i = 1; i < 7; i++) x_q[i] <= x_q[i-1];
      end
      s1_a_q <= acc_t'(x_q[0]) + acc_t'(x_q[6]);
      s1_b_q <= acc_t'(x_q[2]) + acc_t'(x_q[4]);
      s1_c_q <= acc_t'(x_q[3]);
      acc_q  <= (s1_b_q <<< COEF_MID_SH) + s1_b_q + (s1_c_q <<< COEF_CTR_SH) - s1_a_q;
    end
  end

  always_comb begin
    rnd    = (acc_q + acc_t'(RND)) >>> SHIFT;
    dout_d = rnd[DW-1:0];
    ovf_d  = 1'b0;
    if (rnd > acc_t'(SMAX)) begin
      dout_d = sample_t'(SMAX);
      ovf_d  = 1'b1;
    end else if (rnd < acc_t'(SMIN)) begin
      dout_d = sample_t'(SMIN);
      ovf_d  = 1'b1;
    end
  end
`else
  sample_t x0_q, s1_q, s2_q;

  // Same stage count as the filter so output timing is build-independent.
  always_ff @(posedge clk) begin
    if (rst) begin
      x0_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      if (in_vld) x0_q <= din;
      s1_q <= x0_q;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    dout_d = s2_q;
    ovf_d  = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else if (ld) begin
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign dout = dout_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/decim_2x.sv
// Eight-lane 2x decimator: shared phase/fill control and valid pipeline over eight lanes.
// Define DECIM_FIR_EN for the halfband filter; the default build is plain downsampling.
module decim_2x
  import decim_pkg::*;
#(
  parameter bit ODD_PHASE = 1'b1
) (
  input logic       clk,
  input logic       rst,
  decim_2x_if.slave bus
);

  logic               phase_q, phase_d;
  logic [2:0]         fill_q, fill_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic               out_vld_q;
  logic               fire;

  sample_t          din_a  [NLANE];
  sample_t          dout_a [NLANE];
  logic [NLANE-1:0] ovf_a;

  // fill_q counts samples before this one, so >= FILL_MIN-1 means the window is full.
  always_comb begin
    phase_d = phase_q;
    fill_d  = fill_q;
    fire    = 1'b0;
    if (bus.in_vld) begin
      phase_d = ~phase_q;
      if (fill_q != 3'(FILL_MIN)) fill_d = fill_q + 3'd1;
      fire = (phase_q == ODD_PHASE) && (fill_q >= 3'(FILL_MIN - 1));
    end
    vld_d = {vld_q[LATENCY-2:0], fire};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= 1'b0;
      fill_q    <= '0;
      vld_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      fill_q    <= fill_d;
      vld_q     <= vld_d;
      out_vld_q <= vld_q[LATENCY-1];
    end
  end

  assign din_a[0] = bus.din0;
  assign din_a[1] = bus.din1;
  assign din_a[2] = bus.din2;
  assign din_a[3] = bus.din3;
  assign din_a[4] = bus.din4;
  assign din_a[5] = bus.din5;
  assign din_a[6] = bus.din6;
  assign din_a[7] = bus.din7;

  for (genvar n = 0; n < NLANE; n++) begin : g_lane
    decim_hb_ch u_ch (
      .clk    (clk),
      .rst    (rst),
      .in_vld (bus.in_vld),
      .din    (din_a[n]),
      .ld     (vld_q[LATENCY-1]),
      .dout   (dout_a[n]),
      .ovf    (ovf_a[n])
    );
  end

  assign bus.out_vld = out_vld_q;
  assign bus.dout0   = dout_a[0];
  assign bus.dout1   = dout_a[1];
  assign bus.dout2   = dout_a[2];
  assign bus.dout3   = dout_a[3];
  assign bus.dout4   = dout_a[4];
  assign bus.dout5   = dout_a[5];
  assign bus.dout6   = dout_a[6];
  assign bus.dout7   = dout_a[7];
  assign bus.ovf     = ovf_a;

endmodule

// File: tb/tb_decim_2x.sv
// Directed bench for decim_2x; expectations follow DECIM_FIR_EN the same way the RTL does.
module tb_decim_2x;

  logic clk = 1'b0;
  logic rst;

  decim_2x_if bus ();

  decim_2x #(.ODD_PHASE(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #2 clk = ~clk;

  int         vecs = 0;
  int         errs = 0;
  int         smp  [20];
  int         expd [7];
  int         w8   [8];
  logic [7:0] expo;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_lanes(input int base, input int off);
    bus.din0 = 16'(base);
    bus.din1 = 16'(base + off);
    bus.din2 = 16'(base + 2 * off);
    bus.din3 = 16'(base + 3 * off);
    bus.din4 = 16'(base + 4 * off);
    bus.din5 = 16'(base + 5 * off);
    bus.din6 = 16'(base + 6 * off);
    bus.din7 = 16'(base + 7 * off);
  endtask

  function automatic logic signed [15:0] get_dout(input int lane);
    case (lane)
      0:       return bus.dout0;
      3:       return bus.dout3;
      default: return bus.dout7;
    endcase
  endfunction

  // Sample i (1-based) is taken at edge (i-1)*(gap+1)+1; its output shows 3 edges later
  // when i is even and >= 8. Lane k carries smp + k*off, so expects expd + k*off.
  task automatic run(input string tag, input int n, input int gap, input int off,
                     input bit do_rst, input bit mid_rst);
    int per, tot, e, i, k;
    bit ev;
    per = gap + 1;
    if (do_rst) begin
      rst = 1'b1;
      bus.in_vld = 1'b1;
      set_lanes(4660, 0);
      @(posedge clk); #1;
      rst = 1'b0;
    end
    tot = n * per + 4;
    for (int c = 0; c < tot; c++) begin
      if (c < n * per && c % per == 0) begin
        bus.in_vld = 1'b1;
        set_lanes(smp[c / per], off);
      end else begin
        bus.in_vld = 1'b0;
        set_lanes(-7, 0);
      end
      rst = mid_rst && (c == (n - 1) * per + 1);
      @(posedge clk); #1;
      e  = c + 1 - 3;
      ev = 1'b0;
      i  = 0;
      if (e >= 1 && (e - 1) % per == 0) begin
        i  = (e - 1) / per + 1;
        ev = (i <= n) && (i >= 8) && (i % 2 == 0) && !(mid_rst && i == n);
      end
      chk({tag, " out_vld"}, bus.out_vld, ev);
      if (ev) begin
        k = (i - 8) / 2;
        chk({tag, " dout0"}, get_dout(0), expd[k]);
        chk({tag, " dout3"}, get_dout(3), expd[k] + 3 * off);
        chk({tag, " dout7"}, get_dout(7), expd[k] + 7 * off);
        chk({tag, " ovf"}, bus.ovf, expo);
      end
    end
    bus.in_vld = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.in_vld = 1'b0;
    set_lanes(0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_vld", bus.out_vld, 0);
    chk("reset dout0", bus.dout0, 0);
    chk("reset dout7", bus.dout7, 0);
    chk("reset ovf", bus.ovf, 0);
    rst = 1'b0;

    // DC level on every lane
    for (int j = 0; j < 20; j++) smp[j] = 1000;
    for (int j = 0; j < 7; j++) expd[j] = 1000;
    expo = 8'h00;
    run("dc", 20, 0, 1, 1'b1, 1'b0);

    // impulse at sample 8
    for (int j = 0; j < 20; j++) smp[j] = 0;
    smp[7] = 3200;
`ifdef DECIM_FIR_EN
    expd = '{-100, 900, 900, -100, 0, 0, 0};
`else
    expd = '{3200, 0, 0, 0, 0, 0, 0};
`endif
    run("imp8", 16, 0, 0, 1'b1, 1'b0);

    // impulse at sample 9
    for (int j = 0; j < 20; j++) smp[j] = 0;
    smp[8] = 3200;
`ifdef DECIM_FIR_EN
    expd = '{0, 0, 1600, 0, 0, 0, 0};
`else
    expd = '{0, 0, 0, 0, 0, 0, 0};
`endif
    run("imp9", 16, 0, 0, 1'b1, 1'b0);

    // positive clip: samples 1..8, sample 8 is x0
    w8 = '{0, -32768, 0, 32767, 32767, 32767, 0, -32768};
    for (int j = 0; j < 8; j++) smp[j] = w8[j];
`ifdef DECIM_FIR_EN
    expd[0] = 32767;
    expo = 8'hFF;
`else
    expd[0] = -32768;
    expo = 8'h00;
`endif
    run("satpos", 8, 0, 0, 1'b1, 1'b0);

    w8 = '{0, 32767, 0, -32768, -32768, -32768, 0, 32767};
    for (int j = 0; j < 8; j++) smp[j] = w8[j];
`ifdef DECIM_FIR_EN
    expd[0] = -32768;
    expo = 8'hFF;
`else
    expd[0] = 32767;
    expo = 8'h00;
`endif
    run("satneg", 8, 0, 0, 1'b1, 1'b0);

    // rounding: x3 is sample 5 when sample 8 completes
    expo = 8'h00;
    for (int j = 0; j < 20; j++) smp[j] = 0;
    smp[4] = 3;
`ifdef DECIM_FIR_EN
    expd[0] = 2;
`else
    expd[0] = 0;
`endif
    run("rndpos", 8, 0, 0, 1'b1, 1'b0);

    smp[4] = -3;
`ifdef DECIM_FIR_EN
    expd[0] = -1;
`else
    expd[0] = 0;
`endif
    run("rndneg", 8, 0, 0, 1'b1, 1'b0);

    // ramp 100*i: the symmetric filter returns the centre tap x3 = 100*(i-3)
    for (int j = 0; j < 20; j++) smp[j] = 100 * (j + 1);
    for (int j = 0; j < 7; j++) begin
`ifdef DECIM_FIR_EN
      expd[j] = 100 * (5 + 2 * j);
`else
      expd[j] = 100 * (8 + 2 * j);
`endif
    end
    run("ramp", 20, 0, 1, 1'b1, 1'b0);
    run("gap", 20, 2, 1, 1'b1, 1'b0);

    // reset one cycle after the completing sample drops that output
    run("midrst", 8, 0, 0, 1'b1, 1'b1);
    chk("midrst dout0 cleared", bus.dout0, 0);
    chk("midrst ovf cleared", bus.ovf, 0);
    run("refill", 10, 0, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
